// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one request at a time to an external fixed-latency ALU and returns the result with its tag
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready, req_*        request channel (opcode, two operands, caller tag)
//   alu_opcode, alu_value1/2          operands to the ALU, held for the whole BUSY phase
//   alu_result                        ALU result, captured LATENCY+1 cycles after issue
//   rsp_valid/rsp_ready, rsp_*        response channel (result, tag, error flag)
//   stat_ops, stat_errs               wrapping counts of completed responses and of errored ones
module alu_sequencer #(
  parameter int         LATENCY = 1,
  parameter logic [3:0] ADD     = 4'd1,
  parameter logic [3:0] SUB     = 4'd2,
  parameter logic [3:0] MUL     = 4'd3,
  parameter logic [3:0] DIV     = 4'd4,
  parameter logic [3:0] XOR     = 4'd5,
  parameter logic [3:0] AND     = 4'd6,
  parameter logic [3:0] OR      = 4'd7,
  parameter logic [3:0] REM     = 4'd8,
  parameter logic [3:0] NOT     = 4'd9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [3:0]  req_tag,
  output logic [3:0]  alu_opcode,
  output logic [63:0] alu_value1,
  output logic [63:0] alu_value2,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_errs
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, op_q, op_d, tag_q, tag_d;
  logic [63:0] v1_q, v1_d, v2_q, v2_d, res_q, res_d;
  logic        err_q, err_d;
  logic [31:0] stat_ops_q, stat_ops_d, stat_errs_q, stat_errs_d;
  logic        legal, div0, rem0, issue;
  assign legal = req_opcode inside {ADD, SUB, MUL, DIV, XOR, AND, OR, REM, NOT};
  assign div0  = req_opcode == DIV && req_b == '0;
  assign rem0  = req_opcode == REM && req_b == '0;
  // only legal, well-defined operations ever reach the ALU; everything else is answered locally
  assign issue = legal && !div0 && !rem0;
  assign req_ready  = state_q == IDLE;
  assign rsp_valid  = state_q == RESP;
  assign alu_opcode = state_q == BUSY ? op_q : 4'd0;
  assign alu_value1 = v1_q;
  assign alu_value2 = v2_q;
  assign rsp_result = res_q;
  assign rsp_tag    = tag_q;
  assign rsp_err    = err_q;
  assign stat_ops   = stat_ops_q;
  assign stat_errs  = stat_errs_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tag_d       = tag_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    res_d       = res_q;
    err_d       = err_q;
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
    case (state_q)
      IDLE: if (req_valid) begin
        tag_d = req_tag;
        cnt_d = 4'(LATENCY);
        if (issue) begin
          op_d    = req_opcode;
          v1_d    = req_a;
          v2_d    = req_b;
          state_d = BUSY;
        end else begin
          res_d   = div0 ? '1 : req_a;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      // the extra cycle at cnt==0 is where the ALU result is sampled
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        res_d   = alu_result;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        stat_ops_d  = stat_ops_q + 32'd1;
        stat_errs_d = stat_errs_q + 32'(err_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      res_q       <= res_d;
      err_q       <= err_d;
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: transaction-level model of the sequencer plus an ALU model, checked every cycle
module tb_alu_sequencer;
  localparam int L = 1;
  localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4;
  localparam logic [3:0] OP_OR = 4'd7, OP_REM = 4'd8;
  logic        clk = 1'b0;
  logic        reset_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [3:0]  req_opcode, req_tag, alu_opcode, rsp_tag;
  logic [63:0] req_a, req_b, alu_value1, alu_value2, alu_result, rsp_result;
  logic [31:0] stat_ops, stat_errs;
  int          checks = 0, failures = 0;
  bit          busy, m_iss, m_err;
  int          cyc, t_v;
  logic [3:0]  m_op, m_tag;
  logic [63:0] m_v1, m_v2, m_res;
  logic [31:0] m_ops, m_errs;
  int          lat, iss;
  logic [63:0] res;
  logic [3:0]  tg;
  logic        er;
  alu_sequencer #(.LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .stat_ops(stat_ops), .stat_errs(stat_errs)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a * b;
      4'd4: return b == 0 ? '1 : a / b;
      4'd5: return a ^ b;
      4'd6: return a & b;
      4'd7: return a | b;
      4'd8: return b == 0 ? a : a % b;
      4'd9: return ~a;
      default: return 64'd0;
    endcase
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    busy = 0; m_iss = 0; m_err = 0; cyc = 0; t_v = 0;
    m_op = 0; m_tag = 0; m_v1 = 0; m_v2 = 0; m_res = 0; m_ops = 0; m_errs = 0;
  endtask
  task automatic model_update();
    logic legal, zdiv;
    if (!reset_n) return;
    if (busy && cyc >= t_v && rsp_ready) begin
      busy = 0;
      m_ops = m_ops + 32'd1;
      m_errs = m_errs + 32'(m_err);
    end else if (!busy && req_valid) begin
      legal = req_opcode >= 4'd1 && req_opcode <= 4'd9;
      zdiv = (req_opcode == OP_DIV || req_opcode == OP_REM) && req_b == 64'd0;
      busy = 1; m_tag = req_tag; m_iss = legal && !zdiv; m_err = !m_iss;
      if (m_iss) begin
        m_op = req_opcode; m_v1 = req_a; m_v2 = req_b;
        m_res = alu_f(req_opcode, req_a, req_b);
        t_v = cyc + 1 + L + 1;
      end else begin
        m_res = req_opcode == OP_DIV ? '1 : req_a;
        t_v = cyc + 1;
      end
    end
    cyc++;
  endtask
  task automatic compare_all();
    logic exp_rv;
    logic [3:0] exp_op;
    exp_rv = busy && cyc >= t_v;
    exp_op = (busy && m_iss && cyc < t_v) ? m_op : 4'd0;
    check("req_ready", 64'(req_ready), 64'(!busy));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check("alu_opcode", 64'(alu_opcode), 64'(exp_op));
    check("alu_value1", alu_value1, m_v1);
    check("alu_value2", alu_value2, m_v2);
    if (exp_rv) begin
      check("rsp_result", rsp_result, m_res);
      check("rsp_tag", 64'(rsp_tag), 64'(m_tag));
      check("rsp_err", 64'(rsp_err), 64'(m_err));
    end
    check("stat_ops", 64'(stat_ops), 64'(m_ops));
    check("stat_errs", 64'(stat_errs), 64'(m_errs));
  endtask
  task automatic cycle(input logic rv, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag, input logic rr);
    @(negedge clk);
    compare_all();
    alu_result = alu_opcode == 4'd0 ? {$urandom, $urandom} : alu_f(alu_opcode, alu_value1, alu_value2);
    req_valid = rv; req_opcode = op; req_a = a; req_b = b; req_tag = tag; rsp_ready = rr;
    @(posedge clk);
    model_update();
  endtask
  task automatic txn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                     input int hold, output int l, output int n_iss, output logic [63:0] r,
                     output logic [3:0] t, output logic e);
    cycle(1'b1, op, a, b, tag, 1'b0);
    l = 0; n_iss = 0;
    #1;
    while (!rsp_valid && l < 40) begin
      if (alu_opcode != 4'd0) n_iss++;
      cycle(1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 1'b0);
      l++;
      #1;
    end
    check("txn_valid_seen", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      cycle(1'b1, OP_ADD, {$urandom, $urandom}, 64'd1, 4'($urandom_range(0, 15)), 1'b0);
      #1;
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    r = rsp_result; t = rsp_tag; e = rsp_err;
    cycle(1'b1, OP_ADD, 64'd77, 64'd1, 4'd15, 1'b1);
    #1;
  endtask
  initial begin
    reset_n = 1; req_valid = 0; req_opcode = 0; req_a = 0; req_b = 0; req_tag = 0; rsp_ready = 0; alu_result = 0;
    model_reset();
    #1 reset_n = 0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    check("rst_alu_value1", alu_value1, 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_stat_ops", 64'(stat_ops), 64'd0);
    repeat (2) cycle(1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 1'b0);
    #2 reset_n = 1;
    txn(OP_ADD, 64'd5, 64'd7, 4'd3, 0, lat, iss, res, tg, er);
    check("add_latency", 64'(lat), 64'd2);
    check("add_issue_cycles", 64'(iss), 64'd2);
    check("add_result", res, 64'd12);
    check("add_tag", 64'(tg), 64'd3);
    check("add_err", 64'(er), 64'd0);
    check("add_stat_ops", 64'(stat_ops), 64'd1);
    txn(OP_DIV, 64'd100, 64'd0, 4'd5, 0, lat, iss, res, tg, er);
    check("div0_latency", 64'(lat), 64'd0);
    check("div0_issue_cycles", 64'(iss), 64'd0);
    check("div0_result", res, 64'hFFFF_FFFF_FFFF_FFFF);
    check("div0_err", 64'(er), 64'd1);
    check("div0_stat_errs", 64'(stat_errs), 64'd1);
    txn(4'd12, 64'hABCD, 64'd1, 4'd6, 0, lat, iss, res, tg, er);
    check("illegal_issue_cycles", 64'(iss), 64'd0);
    check("illegal_result", res, 64'hABCD);
    check("illegal_err", 64'(er), 64'd1);
    txn(OP_REM, 64'd9, 64'd0, 4'd7, 0, lat, iss, res, tg, er);
    check("rem0_result", res, 64'd9);
    check("rem0_err", 64'(er), 64'd1);
    txn(OP_SUB, 64'd3, 64'd5, 4'd8, 4, lat, iss, res, tg, er);
    check("sub_result", res, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_tag", 64'(tg), 64'd8);
    check("sub_err", 64'(er), 64'd0);
    check("sub_stat_ops", 64'(stat_ops), 64'd5);
    check("sub_stat_errs", 64'(stat_errs), 64'd3);
    cycle(1'b1, OP_MUL, 64'd6, 64'd7, 4'd9, 1'b0);
    #2 reset_n = 0;
    #1;
    check("busy_rst_alu_opcode", 64'(alu_opcode), 64'd0);
    check("busy_rst_alu_value1", alu_value1, 64'd0);
    check("busy_rst_alu_value2", alu_value2, 64'd0);
    check("busy_rst_req_ready", 64'(req_ready), 64'd1);
    check("busy_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("busy_rst_rsp_result", rsp_result, 64'd0);
    check("busy_rst_rsp_tag", 64'(rsp_tag), 64'd0);
    check("busy_rst_stat_ops", 64'(stat_ops), 64'd0);
    check("busy_rst_stat_errs", 64'(stat_errs), 64'd0);
    model_reset();
    repeat (2) cycle(1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 1'b1);
    #2 reset_n = 1;
    txn(OP_ADD, 64'd1, 64'd1, 4'd2, 0, lat, iss, res, tg, er);
    check("post_rst_result", res, 64'd2);
    check("post_rst_latency", 64'(lat), 64'd2);
    check("post_rst_stat_ops", 64'(stat_ops), 64'd1);
    force dut.stat_ops_q = 32'hFFFF_FFFF;
    #1 release dut.stat_ops_q;
    m_ops = 32'hFFFF_FFFF;
    txn(OP_OR, 64'hF0, 64'h0F, 4'd4, 0, lat, iss, res, tg, er);
    check("or_result", res, 64'hFF);
    check("wrap_stat_ops", 64'(stat_ops), 64'd0);
    for (int i = 0; i < 500; i++) begin
      logic [3:0] op;
      logic [63:0] a, b;
      op = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
      a = $urandom_range(0, 1) == 0 ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      b = $urandom_range(0, 3) == 0 ? 64'd0 : {$urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), op, a, b, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    repeat (6) cycle(1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
